line_fill_sched: RTL

LINE_FILL_SCHED -- requirements
Module: line_fill_sched

---
 rtl/line_fill_sched.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/line_fill_sched.sv
// Ping-pong line-buffer fill scheduler: requests one rendered line ahead of the
// VGA scan, writes it into the back bank and swaps banks at each line start.
module line_fill_sched #(
  parameter int H_PIXELS = 640,
  parameter int V_LINES  = 480
) (
  input  logic               CLK25MHZ,
  input  logic               ck_rst,
  input  logic signed [11:0] next_y,
  input  logic               next_line,
  output logic               req_valid,
  output logic        [11:0] req_y,
  input  logic               req_ready,
  input  logic               px_valid,
  input  logic        [11:0] px_data,
  output logic               px_ready,
  output logic               wr_en,
  output logic               wr_bank,
  output logic        [9:0]  wr_addr,
  output logic        [11:0] wr_data,
  output logic               rd_bank,
  output logic               abort,
  output logic               underrun,
  output logic        [15:0] underrun_cnt
);

  localparam logic [1:0] F_REQ  = 2'd0;
  localparam logic [1:0] F_FILL = 2'd1;
  localparam logic [1:0] F_DONE = 2'd2;

  localparam logic [1:0] M_BLANK0 = 2'd0;
  localparam logic [1:0] M_BLANK1 = 2'd1;
  localparam logic [1:0] M_ACTIVE = 2'd2;

  localparam logic        [9:0]  LAST_PX   = 10'(H_PIXELS - 1);
  localparam logic signed [11:0] LAST_LINE = 12'(V_LINES - 1);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic        line_q;
  logic [1:0]  fill_q, fill_d;
  logic [1:0]  mode_q, mode_d;
  logic [11:0] req_y_q, req_y_d;
  logic [9:0]  wr_addr_q, wr_addr_d;
  logic        rd_bank_q, rd_bank_d;
  logic [15:0] underrun_cnt_q, underrun_cnt_d;

  logic line_start;
  logic p1_skip;
  logic act;
  logic fill_done;
  logic miss;
  logic accept;

  // In the second blank line only the start announcing line 1 matters.
  assign line_start = next_line & ~line_q;
  assign p1_skip    = (mode_q == M_BLANK1) && (next_y != 12'sd1);
  assign act        = line_start & ~p1_skip & ~ck_rst;
  assign fill_done  = (fill_q == F_DONE);
  assign miss       = act & ~fill_done;
  assign accept     = px_valid & px_ready;

  assign req_valid    = ~ck_rst & (fill_q == F_REQ);
  assign req_y        = ck_rst ? 12'd0 : req_y_q;
  assign px_ready     = ~ck_rst & (fill_q == F_FILL) & ~act;
  assign wr_en        = accept;
  assign wr_addr      = ck_rst ? 10'd0 : wr_addr_q;
  assign wr_data      = accept ? px_data : 12'd0;
  assign rd_bank      = ~ck_rst & rd_bank_q;
  assign wr_bank      = ~rd_bank;
  assign abort        = miss;
  assign underrun     = miss;
  assign underrun_cnt = ck_rst ? 16'd0 : underrun_cnt_q;

  always_comb begin
    fill_d         = fill_q;
    mode_d         = mode_q;
    req_y_d        = req_y_q;
    wr_addr_d      = wr_addr_q;
    rd_bank_d      = rd_bank_q;
    underrun_cnt_d = underrun_cnt_q;
    if (act) begin
      // A line start always wins over any handshake in the same cycle.
      fill_d    = F_REQ;
      wr_addr_d = 10'd0;
      if (fill_done) begin
        rd_bank_d = ~rd_bank_q;
      end else begin
        underrun_cnt_d = sat_inc16(underrun_cnt_q);
      end
      case (mode_q)
        M_ACTIVE: begin
          if (next_y == LAST_LINE) begin
            req_y_d = 12'd0;
            mode_d  = M_BLANK0;
          end else begin
            req_y_d = $unsigned(next_y) + 12'd1;
          end
        end
        M_BLANK1: begin
          req_y_d = 12'd2;
          mode_d  = M_ACTIVE;
        end
        default: begin
          if (fill_done) begin
            req_y_d = 12'd1;
            mode_d  = M_BLANK1;
          end else begin
            req_y_d = 12'd0;
            mode_d  = M_BLANK0;
          end
        end
      endcase
    end else begin
      case (fill_q)
        F_REQ: begin
          if (req_ready) begin
            fill_d    = F_FILL;
            wr_addr_d = 10'd0;
          end
        end
        F_FILL: begin
          if (accept) begin
            if (wr_addr_q == LAST_PX) begin
              fill_d    = F_DONE;
              wr_addr_d = 10'd0;
            end else begin
              wr_addr_d = wr_addr_q + 10'd1;
            end
          end
        end
        F_DONE: fill_d = F_DONE;
        default: fill_d = F_REQ;
      endcase
    end
  end

  always_ff @(posedge CLK25MHZ) begin
    if (ck_rst) begin
      line_q         <= 1'b0;
      fill_q         <= F_REQ;
      mode_q         <= M_BLANK0;
      req_y_q        <= 12'd0;
      wr_addr_q      <= 10'd0;
      rd_bank_q      <= 1'b0;
      underrun_cnt_q <= 16'd0;
    end else begin
      line_q         <= next_line;
      fill_q         <= fill_d;
      mode_q         <= mode_d;
      req_y_q        <= req_y_d;
      wr_addr_q      <= wr_addr_d;
      rd_bank_q      <= rd_bank_d;
      underrun_cnt_q <= underrun_cnt_d;
    end
  end

endmodule
